fifo_read_streamer: RTL and testbench

Read-side drain stage that sits directly downstream of the 32-entry synchronous FIFO. It watches the FIFO's empty flag and issues read strobes, absorbing the FIFO's one-cycle read latency in a 2-entry holding buffer. It presents the words in order on a valid/ready stream, sustaining one word per cycle under continuous `m_ready`. It never reads an empty FIFO and never drops or duplicates a word while out of reset.

---
 rtl/fifo_stream_pkg.sv | 19 +
 rtl/fifo_stream_skid_buf.sv | 79 +++++++
 rtl/fifo_read_streamer.sv | 78 +++++++
 tb/tb_fifo_read_streamer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_stream_pkg
//  Purpose  : Shared constants and occupancy encoding for the FIFO read streamer.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_stream_pkg;

   localparam int BUF_DEPTH  = 2;
   localparam int WCNT_WIDTH = 16;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

endpackage : fifo_stream_pkg
`default_nettype wire

// File: rtl/fifo_stream_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_stream_skid_buf
//  Purpose  : 2-entry in-order holding buffer; entry 0 is always the head.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_skid_buf
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output occ_t                  occ
);

   occ_t                  r_occ, w_occ_nxt;
   logic [DATA_WIDTH-1:0] r_ent0, r_ent1;
   logic [DATA_WIDTH-1:0] w_ent0_nxt, w_ent1_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_occ  <= OCC_EMPTY;
         r_ent0 <= '0;
         r_ent1 <= '0;
      end else begin
         r_occ  <= w_occ_nxt;
         r_ent0 <= w_ent0_nxt;
         r_ent1 <= w_ent1_nxt;
      end
   end

   // Pop on an empty buffer and push into a full one without a pop cannot be
   // requested by the strobe logic, so both are simply ignored here.
   always_comb begin
      w_occ_nxt  = r_occ;
      w_ent0_nxt = r_ent0;
      w_ent1_nxt = r_ent1;
      case (r_occ)
         OCC_EMPTY: begin
            if (push) begin
               w_ent0_nxt = push_data;
               w_occ_nxt  = OCC_ONE;
            end
         end
         OCC_ONE: begin
            case ({push, pop})
               2'b10: begin
                  w_ent1_nxt = push_data;
                  w_occ_nxt  = OCC_TWO;
               end
               2'b01:   w_occ_nxt  = OCC_EMPTY;
               2'b11:   w_ent0_nxt = push_data;
               default: w_occ_nxt  = OCC_ONE;
            endcase
         end
         OCC_TWO: begin
            if (pop) begin
               w_ent0_nxt = r_ent1;
               if (push) begin
                  w_ent1_nxt = push_data;
               end else begin
                  w_occ_nxt = OCC_ONE;
               end
            end
         end
         default: w_occ_nxt = OCC_EMPTY;
      endcase
   end

   assign head = r_ent0;
   assign occ  = r_occ;

endmodule : fifo_stream_skid_buf
`default_nettype wire

// File: rtl/fifo_read_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_read_streamer
//  Purpose  : Drains a 1-cycle-latency FIFO onto a valid/ready stream.
//             Optional accepted-word counter enabled by FIFO_STREAM_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_read_streamer
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  Read_enable,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  busy
`ifdef FIFO_STREAM_CNT_EN
   ,
   output logic [WCNT_WIDTH-1:0] word_count
`endif
);

   logic       r_inflight;
   logic       w_pop;
   logic [1:0] w_committed;
   occ_t       w_occ;

   assign w_pop   = m_valid && m_ready;
   assign m_valid = (w_occ != OCC_EMPTY);
   assign busy    = m_valid || r_inflight;

   // Slots already spoken for once this cycle's pop is taken into account.
   assign w_committed = w_occ + {1'b0, r_inflight} - {1'b0, w_pop};
   assign Read_enable = !reset && enable && !fifo_empty &&
                        (w_committed < 2'(BUF_DEPTH));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= Read_enable;
      end
   end

   fifo_stream_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (r_inflight),
      .push_data (fifo_data_out),
      .pop       (w_pop),
      .head      (m_data),
      .occ       (w_occ)
   );

`ifdef FIFO_STREAM_CNT_EN
   logic [WCNT_WIDTH-1:0] r_word_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_word_count <= '0;
      end else if (w_pop) begin
         r_word_count <= r_word_count + WCNT_WIDTH'(1);
      end
   end

   assign word_count = r_word_count;
`endif

endmodule : fifo_read_streamer
`default_nettype wire

// File: tb/tb_fifo_read_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_read_streamer
//  Purpose  : Self-checking bench for fifo_read_streamer with a FIFO model
//             and an in-order scoreboard. Build with FIFO_STREAM_CNT_EN for
//             the counter checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_read_streamer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       fifo_empty;
   logic [7:0] fifo_data_out = '0;
   logic       Read_enable;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic       busy;
`ifdef FIFO_STREAM_CNT_EN
   logic [15:0] word_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // FIFO model: one-cycle read latency, reset by the same signal
   logic [7:0] mem [0:4095];
   int         wr_cnt = 0;
   int         rd_cnt = 0;
   logic [7:0] exp_q [$];

   int         str_cnt = 0;
   int         pop_cnt = 0;
   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = '0;

   always #5 clk = ~clk;

   fifo_read_streamer #(
      .DATA_WIDTH (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .fifo_empty    (fifo_empty),
      .fifo_data_out (fifo_data_out),
      .Read_enable   (Read_enable),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .busy          (busy)
`ifdef FIFO_STREAM_CNT_EN
      ,
      .word_count    (word_count)
`endif
   );

   assign fifo_empty = (wr_cnt == rd_cnt);

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_cnt        <= 0;
         fifo_data_out <= '0;
      end else if (Read_enable) begin
         fifo_data_out <= mem[rd_cnt[11:0]];
         rd_cnt        <= rd_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] d);
      mem[wr_cnt[11:0]] = d;
      wr_cnt++;
      exp_q.push_back(d);
   endtask

   task automatic drain(input bit toggle, input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < limit) begin
         m_ready = toggle ? ~m_ready : 1'b1;
         step();
         n++;
      end
      check("drain_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
      check("fifo_drained", 32'(fifo_empty), 32'd1);
      m_ready = 1'b1;
   endtask

   // Monitor samples just before each rising edge, after stimulus has settled
   always @(negedge clk) begin
      #3;
      if (reset) begin
         str_cnt   = 0;
         pop_cnt   = 0;
         prev_hold = 1'b0;
      end else begin
         if (Read_enable) begin
            check("rd_not_empty", 32'(fifo_empty), 32'd0);
            check("rd_has_room",
                  32'((str_cnt - pop_cnt - ((m_valid && m_ready) ? 1 : 0)) < 2), 32'd1);
            str_cnt++;
         end
         if (prev_hold) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", 32'(m_data), 32'(prev_data));
         end
         if (m_valid && m_ready) begin
            check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               check("data", 32'(m_data), 32'(exp_q.pop_front()));
            end
            pop_cnt++;
         end
         prev_hold = m_valid && !m_ready;
         prev_data = m_data;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s;
      int p;
      int loaded;
      int n;

      step();
      step();
      check("rst_rd", 32'(Read_enable), 32'd0);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_data", 32'(m_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
`ifdef FIFO_STREAM_CNT_EN
      check("rst_wc", 32'(word_count), 32'd0);
`endif
      reset = 1'b0;
      step();

      // First-word latency and a back-to-back burst of five
      enable  = 1'b1;
      m_ready = 1'b1;
      for (int i = 1; i <= 5; i++) load(8'(i));
      step();
      check("lat_t1_valid", 32'(m_valid), 32'd0);
      step();
      check("lat_t2_valid", 32'(m_valid), 32'd1);
      check("lat_t2_data", 32'(m_data), 32'h01);
      for (int k = 0; k < 4; k++) begin
         step();
         check("burst_valid", 32'(m_valid), 32'd1);
      end
      step();
      check("burst_end_valid", 32'(m_valid), 32'd0);
      check("burst_end_busy", 32'(busy), 32'd0);
      check("burst_sb_empty", 32'(exp_q.size()), 32'd0);

      // 32 words with ready toggling every cycle
      for (int i = 0; i < 32; i++) load(8'(8'h40 + i));
      drain(1'b1, 400);

      // Ten cycles of backpressure mid-stream
      for (int i = 0; i < 20; i++) load(8'(8'h80 + i));
      for (int k = 0; k < 5; k++) step();
      m_ready = 1'b0;
      for (int k = 0; k < 10; k++) step();
      check("bp_rd_low", 32'(Read_enable), 32'd0);
      check("bp_valid", 32'(m_valid), 32'd1);
      check("bp_held", 32'(str_cnt - pop_cnt), 32'd2);
      m_ready = 1'b1;
      #1;
      check("bp_no_bubble", 32'(Read_enable), 32'd1);
      step();
      check("bp_resume_valid", 32'(m_valid), 32'd1);
      drain(1'b0, 100);

      // Enable dropped right after a strobe
      enable = 1'b0;
      for (int i = 0; i < 6; i++) load(8'(8'hA0 + i));
      #1;
      check("en_off_rd", 32'(Read_enable), 32'd0);
      s = str_cnt;
      p = pop_cnt;
      enable = 1'b1;
      step();
      enable = 1'b0;
      #1;
      check("en_drop_rd", 32'(Read_enable), 32'd0);
      for (int k = 0; k < 4; k++) step();
      check("en_one_strobe", 32'(str_cnt - s), 32'd1);
      check("en_one_word", 32'(pop_cnt - p), 32'd1);
      check("en_idle_busy", 32'(busy), 32'd0);
      enable = 1'b1;
      drain(1'b0, 100);

      // Reset in the middle of a stream
      for (int i = 0; i < 10; i++) load(8'(8'hC0 + i));
      for (int k = 0; k < 4; k++) step();
      check("pre_rst_busy", 32'(busy), 32'd1);
      reset  = 1'b1;
      wr_cnt = 0;
      exp_q.delete();
      #1;
      check("mid_rst_rd", 32'(Read_enable), 32'd0);
      check("mid_rst_valid", 32'(m_valid), 32'd0);
      check("mid_rst_data", 32'(m_data), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
`ifdef FIFO_STREAM_CNT_EN
      check("mid_rst_wc", 32'(word_count), 32'd0);
`endif
      step();
      step();
      reset = 1'b0;
      step();
      check("post_rst_valid", 32'(m_valid), 32'd0);
      check("post_rst_rd", 32'(Read_enable), 32'd0);
      for (int i = 0; i < 3; i++) load(8'(8'hE0 + i));
      drain(1'b0, 50);
`ifdef FIFO_STREAM_CNT_EN
      check("wc_after_rst", 32'(word_count), 32'd3);

      // Counter wrap: 65537 accepted words leave the count at 1
      reset  = 1'b1;
      wr_cnt = 0;
      exp_q.delete();
      step();
      reset = 1'b0;
      step();
      check("wc_zero", 32'(word_count), 32'd0);
      loaded = 0;
      n      = 0;
      while (loaded < 65537 && n < 70000) begin
         for (int j = 0; j < 2; j++) begin
            if (loaded < 65537 && (wr_cnt - rd_cnt) < 16) begin
               load(8'(loaded));
               loaded++;
            end
         end
         step();
         n++;
      end
      check("wc_loaded", 32'(loaded), 32'd65537);
      drain(1'b0, 100);
      check("wc_wrap", 32'(word_count), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fifo_read_streamer
`default_nettype wire
